vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator: successor to the fixed-constant VGA state machine. It owns its own horizontal and vertical position counters and drives sync, data-enable and pixel coordinates. Porch, sync and active lengths and sync polarities are set per parameter, and advancement is gated by a pixel-clock enable. It sits between the pixel clock domain and the frame-buffer reader / DAC output stage.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 1'b0, asserted level of `hs_o` (0 = active-low)
- `VS_POL`, 1'b0, asserted level of `vs_o`
- `CNT_W`, 11, width of position counters; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- `clk_i` in 1 system clock
- `rst_ni` in 1 asynchronous, active-low reset
- `en_i` in 1 pixel tick; state advances only on clock edges where `en_i`=1
- `hs_o` out 1 horizontal sync, level per `HS_POL`
- `vs_o` out 1 vertical sync, level per `VS_POL`
- `de_o` out 1 data enable, high only when both axes are ACTIVE
- `x_o` out CNT_W horizontal position, 0..H_TOTAL-1
- `y_o` out CNT_W vertical position, 0..V_TOTAL-1
- `line_start_o` out 1 one-tick pulse at x=0
- `frame_start_o` out 1 one-tick pulse at x=0, y=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise. Both are computed in the package functions at CNT_W bits.
- Each axis has a Moore FSM ACTIVE→FP→SYNC→BP→ACTIVE with a position counter. The axis is in:
  - ACTIVE at pos 0..ACTIVE-1
  - FP at ACTIVE..ACTIVE+FP-1
  - SYNC for the next SYNC positions
  - BP for the last BP positions
- Horizontal axis steps on every `en_i`. At H_TOTAL-1 it wraps to 0 and issues a step to the vertical axis.
- Vertical axis steps only on that horizontal wrap. It wraps from V_TOTAL-1 to 0.
- `hs_o` = HS_POL while the H state is SYNC, otherwise ~HS_POL. `vs_o` follows the same rule using the V state.
- `vs_o` changes on the same tick as the horizontal wrap, i.e. aligned to x=0.
- `line_start_o` = (x=0); `frame_start_o` = (x=0 and y=0). Both are high for exactly one enabled tick, since outputs hold between ticks.
- Zero-length porch (`H_FP`=0 or `H_BP`=0, and the V equivalents) skips that state. `*_ACTIVE` and `*_SYNC` must be ≥1; elaboration fails otherwise.

## Timing
- All outputs are registered. On an edge with `en_i`=1, position registers load pos_next, and outputs load the decode of pos_next in the same edge. Outputs and x/y therefore have zero skew, and nothing is combinational from state to port.
- `en_i`=0: all registers, including pulses, hold their value.
- Reset (`rst_ni`=0, asynchronous, any time including mid-line or mid-sync):
  - position = (H_TOTAL-1, V_TOTAL-1); H and V states = BP
  - `x_o`=H_TOTAL-1, `y_o`=V_TOTAL-1
  - `de_o`=0, `hs_o`=~HS_POL, `vs_o`=~VS_POL
  - `line_start_o`=0, `frame_start_o`=0
- First `en_i` tick after reset release: x=0, y=0, `de_o`=1, `line_start_o`=1, `frame_start_o`=1. A frame therefore starts one enabled tick after reset.
- Latency from `en_i` to output update: one clock edge.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in a single tick. No intermediate value is visible.

## Structure
- Package `vga_pkg`:
  - `axis_state_t` enum {ACTIVE, FP, SYNC, BP}, logic [1:0]
  - function `total(active, fp, sync, bp)`
  - default 640x480@60 constants
- Sub-module `vga_axis`:
  - parameters ACTIVE/FP/SYNC/BP/CNT_W
  - ports `clk_i`, `rst_ni`, `step_i`, `pos_o`, `state_o`, `wrap_o` (combinational, high when step_i and pos=TOTAL-1)
  - instantiated twice in `vga_timing_gen`; H `wrap_o` drives V `step_i`
- Top adds polarity mapping, DE/pulse decode and the output registers.

## Test plan
- Reset with `en_i`=1 held → during reset:
  - `x_o`=799, `y_o`=524, `de_o`=0, `hs_o`=1, `vs_o`=1
  - first tick after release: x=0, y=0, `de_o`=1, `frame_start_o`=1
- One full line at defaults:
  - `de_o` high for exactly 640 ticks (x 0..639)
  - `hs_o`=0 exactly for x 656..751
  - `line_start_o` period 800 ticks
- Full frame:
  - `vs_o`=0 exactly for y 490..491, switching at x=0
  - `frame_start_o` period 420000 ticks
  - no `de_o` for y≥480
- Toggle `en_i` randomly at ~30% duty → outputs are identical to the `en_i`=1 run once indexed by enabled ticks; all outputs stable while `en_i`=0.
- Assert `rst_ni` low at x=700 (inside hsync), y=100 → outputs go to reset values immediately without waiting for a clock; resume at (0,0) after release.
- Tiny config H 4/0/2/1, V 3/1/1/0, `HS_POL`=`VS_POL`=1:
  - H_TOTAL=7, V_TOTAL=5
  - `hs_o`=1 exactly at x 4..5; FP state skipped
  - `vs_o`=1 exactly at y=4
  - wrap (6,4)→(0,0) in one tick

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing constants and the line/frame
// length helper used by the VGA timing generator and its axis counters.
package vga_pkg;

    // Phase of one axis (horizontal or vertical) within a line or frame.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } axis_state_t;

    // Default 640x480@60 timing (25.175 MHz pixel tick).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W_DEF    = 11;

    // Positions per line (or lines per frame); callers size it to CNT_W.
    function automatic int total(input int active, input int fp,
                                 input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis.sv
// One timing axis: position counter plus ACTIVE->FP->SYNC->BP phase FSM.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   step_i        - advance one position on this edge
//   pos_o         - registered position, 0..TOTAL-1
//   state_o       - phase the axis enters on this edge (current phase when
//                   step_i=0), so the owner can register a decode of it
//   wrap_o        - combinational, high when step_i and pos_o = TOTAL-1
module vga_axis #(
    parameter int ACTIVE = vga_pkg::H_ACTIVE_DEF,
    parameter int FP     = vga_pkg::H_FP_DEF,
    parameter int SYNC   = vga_pkg::H_SYNC_DEF,
    parameter int BP     = vga_pkg::H_BP_DEF,
    parameter int CNT_W  = vga_pkg::CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 step_i,
    output logic [CNT_W-1:0]     pos_o,
    output vga_pkg::axis_state_t state_o,
    output logic                 wrap_o
);

    // Parameter names shadow the enum literals, so literals are qualified.
    localparam int TOTAL = vga_pkg::total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

    if (ACTIVE < 1 || SYNC < 1) begin : g_bad_len
        $error("vga_axis: ACTIVE and SYNC must both be at least 1");
    end

    vga_pkg::axis_state_t state;
    vga_pkg::axis_state_t state_next;
    logic [CNT_W-1:0]     pos_next;

    assign wrap_o  = step_i && (pos_o == LAST);
    assign state_o = state_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pos_next = pos_o;
        if (step_i) begin
            pos_next = wrap_o ? '0 : pos_o + CNT_W'(1);
        end
    end

    // Boundaries are tested on pos_next so the phase changes on the same
    // edge as the position that enters it. Zero-length porches are skipped
    // by jumping straight to the following phase.
    always_comb begin
        state_next = state;
        if (step_i) begin
            case (state)
                vga_pkg::ACTIVE: begin
                    if (pos_next == FP_START) begin
                        state_next = (FP != 0) ? vga_pkg::FP : vga_pkg::SYNC;
                    end
                end
                vga_pkg::FP: begin
                    if (pos_next == SYNC_START) state_next = vga_pkg::SYNC;
                end
                vga_pkg::SYNC: begin
                    // BP_START equals TOTAL when BP=0 and may alias 0, so guard it.
                    if (BP != 0 && pos_next == BP_START) state_next = vga_pkg::BP;
                    else if (wrap_o)                     state_next = vga_pkg::ACTIVE;
                end
                default: begin
                    if (wrap_o) state_next = vga_pkg::ACTIVE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_o <= LAST;
            state <= vga_pkg::BP;
        end else begin
            pos_o <= pos_next;
            state <= state_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: horizontal and vertical axis counters
// with registered sync, data-enable and line/frame start pulses.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   en_i           - pixel tick; everything advances only when high
//   hs_o, vs_o     - syncs, asserted level HS_POL / VS_POL
//   de_o           - high when both axes are in ACTIVE
//   x_o, y_o       - current position
//   line_start_o   - high while x=0; frame_start_o - high while x=0, y=0
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             line_start_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL or V_TOTAL");
    end

    logic [CNT_W-1:0] h_pos;
    logic [CNT_W-1:0] v_pos;
    axis_state_t      h_state_next;
    axis_state_t      v_state_next;
    logic             h_wrap;
    logic             v_wrap;

    vga_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .step_i (en_i),
        .pos_o  (h_pos),
        .state_o(h_state_next),
        .wrap_o (h_wrap)
    );

    // The vertical axis only moves on the horizontal wrap, so a combined
    // wrap at (H_TOTAL-1, V_TOTAL-1) lands on (0,0) in one edge.
    vga_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .step_i (h_wrap),
        .pos_o  (v_pos),
        .state_o(v_state_next),
        .wrap_o (v_wrap)
    );

    assign x_o = h_pos;
    assign y_o = v_pos;

    // Flags are registered from the axes' next phase/wrap so they change on
    // the same edge as x/y. A wrap is exactly "next position is 0".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            de_o          <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            hs_o          <= (h_state_next == SYNC) ? HS_POL : ~HS_POL;
            vs_o          <= (v_state_next == SYNC) ? VS_POL : ~VS_POL;
            de_o          <= (h_state_next == ACTIVE) && (v_state_next == ACTIVE);
            line_start_o  <= h_wrap;
            frame_start_o <= v_wrap;
        end
    end

endmodule
